// File: rtl/instr_fetch.sv
// Instruction fetch stage: next-PC selection, credit-limited in-order memory requests,
// and a small FIFO of {pc, instr} pairs toward decode, with redirect flush and stale-response drop.
module instr_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

    logic [CW-1:0] outstanding;
    logic [CW-1:0] count;
    logic [CW-1:0] drop;
    logic [PW-1:0] fifo_wr, fifo_rd;
    logic [PW-1:0] aq_wr, aq_rd;

    logic [31:0] fifo_instr [DEPTH];
    logic [31:0] fifo_pc    [DEPTH];
    logic [31:0] aq_pc      [DEPTH];

    logic [CW:0] credit_used;
    logic        req_fire;
    logic        rsp_fire;
    logic        rsp_keep;
    logic        pop;

    // In-flight requests and buffered entries share one credit pool, so a
    // returning response always finds room in the FIFO.
    assign credit_used    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < CAP);
    assign imem_req_addr  = pc_cur;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep = rsp_fire && !redirect_valid && (drop == '0);
    assign pop      = (count != '0) && if_ready && !redirect_valid;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pc_next = pc_cur;
        if (reset)
            pc_next = RESET_PC;
        else if (redirect_valid)
            pc_next = redirect_target & ~32'h3;
        else if (req_fire)
            pc_next = pc_cur + 32'd4;
    end

    // NOTE: sequential state is updated only with non-blocking assignments so all
    // flops see pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            count       <= '0;
            drop        <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (req_fire)
                aq_wr <= aq_wr + PW'(1);
            if (rsp_fire)
                aq_rd <= aq_rd + PW'(1);

            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                drop    <= outstanding - CW'(rsp_fire);
                count   <= '0;
                fifo_rd <= fifo_wr;
            end else begin
                if (rsp_fire && (drop != '0))
                    drop <= drop - CW'(1);
                count <= count + CW'(rsp_keep) - CW'(pop);
                if (rsp_keep)
                    fifo_wr <= fifo_wr + PW'(1);
                if (pop)
                    fifo_rd <= fifo_rd + PW'(1);
            end
        end
    end

    // NOTE: storage arrays carry no reset; the pointers and counters above decide
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (req_fire)
            aq_pc[aq_wr] <= pc_cur;
        if (rsp_keep) begin
            fifo_instr[fifo_wr] <= imem_rsp_data;
            fifo_pc[fifo_wr]    <= aq_pc[aq_rd];
        end
    end

    assign if_valid = (count != '0);
    assign if_instr = if_valid ? fifo_instr[fifo_rd] : NOP;
    assign if_pc    = if_valid ? fifo_pc[fifo_rd]    : 32'h0;

endmodule
